// File: rtl/pu_pkg.sv
// Shared types and defaults for the power-up pickup logic.
// Power-up classification and FSM state encodings live here.
package pu_pkg;

  typedef enum logic [1:0] {
    PU_NONE  = 2'b00,
    PU_BOMB  = 2'b01,
    PU_BLAST = 2'b10,
    PU_SPEED = 2'b11
  } powerup_t;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    APPLY,
    COOLDOWN
  } pu_state_t;

  localparam int unsigned BLAST_INIT_DEF    = 1;
  localparam int unsigned BLAST_MAX_DEF     = 5;
  localparam int unsigned BOOST_SECONDS_DEF = 10;

  // Saturating increment of the blast radius.
  function automatic logic [2:0] blast_step(input logic [2:0] cur, input logic [2:0] ceiling);
    return (cur < ceiling) ? cur + 3'd1 : cur;
  endfunction

endpackage

// File: rtl/powerup_controller_if.sv
// Frame/timing inputs, sprite overlap inputs and effect outputs of the power-up controller.
// There is no back-pressure: inc_bomb and collect_pulse are single-cycle strobes consumers must accept.
interface powerup_controller_if;
  import pu_pkg::*;

  logic       startOfFrame;
  logic       OneSecPulse;
  logic       player_DR;
  logic       powerup_DR;
  logic [1:0] powerup_type;
  logic       score_reset;

  logic       inc_bomb;
  logic [2:0] blast_num;
  logic       speed_boost;
  logic [3:0] boost_left;
  logic       collect_pulse;
  pu_state_t  dbg_state;

  modport master (
    output startOfFrame, OneSecPulse, player_DR, powerup_DR, powerup_type, score_reset,
    input  inc_bomb, blast_num, speed_boost, boost_left, collect_pulse, dbg_state
  );

  modport slave (
    input  startOfFrame, OneSecPulse, player_DR, powerup_DR, powerup_type, score_reset,
    output inc_bomb, blast_num, speed_boost, boost_left, collect_pulse, dbg_state
  );

endinterface

// File: rtl/powerup_boost_timer.sv
// Speed-boost countdown: reloads on a SPEED pickup and counts down once per second.
// A reload in the same cycle as a second tick wins; the count never wraps below zero.
module powerup_boost_timer
  import pu_pkg::*;
#(
  parameter int unsigned BOOST_SECONDS = BOOST_SECONDS_DEF
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       clear,
  input  logic       load,
  input  logic       one_sec_pulse,
  output logic [3:0] boost_left,
  output logic       speed_boost
);

  localparam logic [3:0] BOOST_V = 4'(BOOST_SECONDS);

  logic [3:0] next_left;

  always_comb begin
    next_left = boost_left;
    if (clear) begin
      next_left = 4'd0;
    end else if (load) begin
      next_left = BOOST_V;
    end else if (one_sec_pulse && (boost_left != 4'd0)) begin
      next_left = boost_left - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      boost_left  <= 4'd0;
      speed_boost <= 1'b0;
    end else begin
      boost_left  <= next_left;
      speed_boost <= (next_left != 4'd0);
    end
  end

endmodule

// File: rtl/powerup_controller.sv
// Detects player/power-up overlap, applies the pickup effect at the end of the frame,
// then locks out further pickups until a whole frame passes without overlap.
module powerup_controller
  import pu_pkg::*;
#(
  parameter int unsigned BLAST_INIT    = BLAST_INIT_DEF,
  parameter int unsigned BLAST_MAX     = BLAST_MAX_DEF,
  parameter int unsigned BOOST_SECONDS = BOOST_SECONDS_DEF
) (
  input  logic               clk,
  input  logic               resetN,
  powerup_controller_if.slave bus
);

  localparam logic [2:0] BLAST_INIT_V = 3'(BLAST_INIT);
  localparam logic [2:0] BLAST_MAX_V  = 3'(BLAST_MAX);

  pu_state_t  state, state_nxt;
  powerup_t   latched, latched_nxt;
  logic       overlap, overlap_nxt;
  logic       hit;
  logic       in_apply;
  logic       apply_bomb;
  logic       apply_blast;
  logic       apply_speed;
  logic [2:0] blast_q;
  logic       inc_q;
  logic       collect_q;

  assign hit         = bus.player_DR & bus.powerup_DR & (bus.powerup_type != PU_NONE);
  assign in_apply    = (state == APPLY);
  assign apply_bomb  = in_apply & (latched == PU_BOMB)  & ~bus.score_reset;
  assign apply_blast = in_apply & (latched == PU_BLAST) & ~bus.score_reset;
  assign apply_speed = in_apply & (latched == PU_SPEED);

  always_comb begin
    state_nxt   = state;
    latched_nxt = latched;
    overlap_nxt = overlap;
    unique case (state)
      IDLE: begin
        if (hit) begin
          latched_nxt = powerup_t'(bus.powerup_type);
          state_nxt   = PENDING;
        end
      end
      PENDING: begin
        if (bus.startOfFrame) state_nxt = APPLY;
      end
      APPLY: begin
        state_nxt   = COOLDOWN;
        overlap_nxt = 1'b0;
      end
      COOLDOWN: begin
        // The frame boundary judges the frame just ended, then starts a fresh one.
        if (bus.startOfFrame) begin
          overlap_nxt = 1'b0;
          if (!overlap) state_nxt = IDLE;
        end else if (hit) begin
          overlap_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.score_reset) begin
      state_nxt   = IDLE;
      latched_nxt = PU_NONE;
      overlap_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      latched   <= PU_NONE;
      overlap   <= 1'b0;
      blast_q   <= BLAST_INIT_V;
      inc_q     <= 1'b0;
      collect_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      latched   <= latched_nxt;
      overlap   <= overlap_nxt;
      inc_q     <= apply_bomb;
      collect_q <= in_apply & ~bus.score_reset;
      if (bus.score_reset) begin
        blast_q <= BLAST_INIT_V;
      end else if (apply_blast) begin
        blast_q <= blast_step(blast_q, BLAST_MAX_V);
      end
    end
  end

  powerup_boost_timer #(
    .BOOST_SECONDS(BOOST_SECONDS)
  ) u_boost_timer (
    .clk          (clk),
    .resetN       (resetN),
    .clear        (bus.score_reset),
    .load         (apply_speed),
    .one_sec_pulse(bus.OneSecPulse),
    .boost_left   (bus.boost_left),
    .speed_boost  (bus.speed_boost)
  );

  assign bus.inc_bomb      = inc_q;
  assign bus.collect_pulse = collect_q;
  assign bus.blast_num     = blast_q;
  assign bus.dbg_state     = state;

endmodule
